// File: rtl/ai_pilot_pkg.sv
// Shared types and default tuning constants for the auto-pilot that plays the runner game.
package ai_pilot_pkg;

  localparam int unsigned CNT_W                 = 8;
  localparam int unsigned DEF_NUM_OBS           = 2;
  localparam int unsigned DEF_PLAYER_OFFSET     = 6;
  localparam int unsigned DEF_JUMP_THRESHOLD    = 30;
  localparam int unsigned DEF_DUCK_THRESHOLD    = 40;
  localparam int unsigned DEF_JUMP_HOLD         = 4;
  localparam int unsigned DEF_RESTART_DELAY     = 60;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_JUMP,
    ST_DUCK,
    ST_CRASHED,
    ST_START
  } state_e;

  typedef struct packed {
    logic start;
    logic up;
    logic down;
  } buttons_t;

endpackage

// File: rtl/obstacle_window.sv
// Classifies one obstacle channel as a jump threat or a duck threat.
module obstacle_window
  import ai_pilot_pkg::*;
#(
  parameter int unsigned POS_W          = 10,
  parameter int unsigned PLAYER_OFFSET  = DEF_PLAYER_OFFSET,
  parameter int unsigned JUMP_THRESHOLD = DEF_JUMP_THRESHOLD,
  parameter int unsigned DUCK_THRESHOLD = DEF_DUCK_THRESHOLD
) (
  input  logic [POS_W-1:0] pos,
  input  logic             is_bird,
  output logic             jump_threat_c,
  output logic             duck_threat_c
);

  logic [31:0] pos_ext;
  logic        ahead_c;

  // Compare at 32 bits so thresholds wider than the position never truncate.
  assign pos_ext       = 32'(pos);
  assign ahead_c       = pos_ext > PLAYER_OFFSET;
  assign jump_threat_c = ahead_c && !is_bird && (pos_ext <= JUMP_THRESHOLD);
  assign duck_threat_c = ahead_c &&  is_bird && (pos_ext <= DUCK_THRESHOLD);

endmodule

// File: rtl/ai_pilot.sv
// Auto-pilot: watches obstacle channels and drives jump/duck/start buttons unless a gamepad is present.
module ai_pilot
  import ai_pilot_pkg::*;
#(
  parameter int unsigned CONV           = 0,
  parameter int unsigned NUM_OBS        = DEF_NUM_OBS,
  parameter int unsigned PLAYER_OFFSET  = DEF_PLAYER_OFFSET,
  parameter int unsigned JUMP_THRESHOLD = DEF_JUMP_THRESHOLD,
  parameter int unsigned DUCK_THRESHOLD = DEF_DUCK_THRESHOLD,
  parameter int unsigned JUMP_HOLD      = DEF_JUMP_HOLD,
  parameter int unsigned RESTART_DELAY  = DEF_RESTART_DELAY,
  localparam int unsigned POS_W         = 10 - CONV
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     frame_tick,
  input  logic                     gamepad_is_present,
  input  logic                     gamepad_start,
  input  logic                     gamepad_up,
  input  logic                     gamepad_down,
  input  logic [NUM_OBS*POS_W-1:0] obstacle_pos,
  input  logic [NUM_OBS-1:0]       obstacle_is_bird,
  input  logic                     crash,
  output logic                     button_start,
  output logic                     button_up,
  output logic                     button_down,
  output logic                     ai_active
);

  logic [NUM_OBS-1:0] jump_vec_c;
  logic [NUM_OBS-1:0] duck_vec_c;
  logic               jump_req_c;
  logic               duck_req_c;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  buttons_t           btn_q, btn_d;
  logic               gp_q;

  for (genvar i = 0; i < NUM_OBS; i++) begin : g_win
    obstacle_window #(
      .POS_W          (POS_W),
      .PLAYER_OFFSET  (PLAYER_OFFSET),
      .JUMP_THRESHOLD (JUMP_THRESHOLD),
      .DUCK_THRESHOLD (DUCK_THRESHOLD)
    ) u_win (
      .pos           (obstacle_pos[i*POS_W +: POS_W]),
      .is_bird       (obstacle_is_bird[i]),
      .jump_threat_c (jump_vec_c[i]),
      .duck_threat_c (duck_vec_c[i])
    );
  end

  assign jump_req_c = |jump_vec_c;
  assign duck_req_c = |duck_vec_c;

  // State, shared hold/delay counter and registered buttons.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_RUN;
      cnt_q     <= '0;
      btn_q     <= '0;
      ai_active <= 1'b1;
      gp_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      btn_q     <= btn_d;
      ai_active <= !gamepad_is_present;
      gp_q      <= gamepad_is_present;
    end
  end

  // Next state; buttons are decoded from the next state so they land with it.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    btn_d   = '0;
    if (gamepad_is_present) begin
      state_d    = ST_RUN;
      cnt_d      = '0;
      btn_d.start = gamepad_start;
      btn_d.up    = gamepad_up;
      btn_d.down  = gamepad_down;
    end else if (gp_q) begin
      // First AI cycle after a handover stays idle before deciding anything.
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (crash) begin
            state_d = ST_CRASHED;
            cnt_d   = CNT_W'(RESTART_DELAY);
          end else if (jump_req_c) begin
            state_d = ST_JUMP;
            cnt_d   = CNT_W'(JUMP_HOLD);
          end else if (duck_req_c) begin
            state_d = ST_DUCK;
          end
        end
        ST_JUMP: begin
          if (crash) begin
            state_d = ST_CRASHED;
            cnt_d   = CNT_W'(RESTART_DELAY);
          end else if (frame_tick) begin
            if (cnt_q == CNT_W'(1)) begin
              state_d = ST_RUN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        ST_DUCK: begin
          if (crash) begin
            state_d = ST_CRASHED;
            cnt_d   = CNT_W'(RESTART_DELAY);
          end else if (jump_req_c) begin
            state_d = ST_JUMP;
            cnt_d   = CNT_W'(JUMP_HOLD);
          end else if (!duck_req_c) begin
            state_d = ST_RUN;
          end
        end
        ST_CRASHED: begin
          if (cnt_q == '0) begin
            state_d = ST_START;
          end else if (frame_tick) begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_START: begin
          if (frame_tick && !crash) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_RUN;
      endcase
      btn_d.start = (state_d == ST_START);
      btn_d.up    = (state_d == ST_JUMP);
      btn_d.down  = (state_d == ST_DUCK);
    end
  end

  assign button_start = btn_q.start;
  assign button_up    = btn_q.up;
  assign button_down  = btn_q.down;

endmodule

// File: tb/tb_ai_pilot.sv
// Bench for ai_pilot: directed scenarios plus randomized play against a behavioural model.
module tb_ai_pilot;

  localparam int unsigned NUM_OBS = 2;
  localparam int unsigned POS_W   = 10;
  localparam int P_OFF   = 6;
  localparam int J_TH    = 30;
  localparam int D_TH    = 40;
  localparam int J_HOLD  = 4;
  localparam int M_RUN = 0, M_JUMP = 1, M_DUCK = 2, M_CRASHED = 3, M_START = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_tick = 1'b0;
  logic gamepad_is_present = 1'b0;
  logic gamepad_start = 1'b0;
  logic gamepad_up = 1'b0;
  logic gamepad_down = 1'b0;
  logic [NUM_OBS*POS_W-1:0] obstacle_pos = '0;
  logic [NUM_OBS-1:0]       obstacle_is_bird = '0;
  logic crash = 1'b0;
  logic s0, u0, d0, a0;
  logic s1, u1, d1, a1;

  ai_pilot dut (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .gamepad_is_present(gamepad_is_present), .gamepad_start(gamepad_start),
    .gamepad_up(gamepad_up), .gamepad_down(gamepad_down),
    .obstacle_pos(obstacle_pos), .obstacle_is_bird(obstacle_is_bird), .crash(crash),
    .button_start(s0), .button_up(u0), .button_down(d0), .ai_active(a0)
  );

  ai_pilot #(.RESTART_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .frame_tick(frame_tick),
    .gamepad_is_present(gamepad_is_present), .gamepad_start(gamepad_start),
    .gamepad_up(gamepad_up), .gamepad_down(gamepad_down),
    .obstacle_pos(obstacle_pos), .obstacle_is_bird(obstacle_is_bird), .crash(crash),
    .button_start(s1), .button_up(u1), .button_down(d1), .ai_active(a1)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int ticks;
  bit tick_seen = 1'b0;
  bit tick_rand = 1'b0;
  bit started;
  int       m_mode[2];
  int       m_left[2];
  bit       m_prev[2];
  logic [3:0] m_out[2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_pos(input int ch, input int val);
    obstacle_pos[ch*POS_W +: POS_W] = POS_W'(val);
  endtask

  function automatic void threats(output bit jr, output bit dr);
    int p;
    jr = 1'b0;
    dr = 1'b0;
    for (int i = 0; i < int'(NUM_OBS); i++) begin
      p = int'(obstacle_pos[i*POS_W +: POS_W]);
      if (p > P_OFF) begin
        if (obstacle_is_bird[i]) begin
          if (p <= D_TH) dr = 1'b1;
        end else if (p <= J_TH) begin
          jr = 1'b1;
        end
      end
    end
  endfunction

  task automatic model_reset(input int k);
    m_mode[k] = M_RUN;
    m_left[k] = 0;
    m_prev[k] = 1'b0;
    m_out[k]  = 4'b0001;
  endtask

  // Outputs packed as {start, up, down, ai_active}.
  task automatic model_step(input int k, input int delay);
    bit jr, dr;
    threats(jr, dr);
    if (gamepad_is_present) begin
      m_mode[k] = M_RUN;
      m_left[k] = 0;
      m_prev[k] = 1'b1;
      m_out[k]  = {gamepad_start, gamepad_up, gamepad_down, 1'b0};
    end else if (m_prev[k]) begin
      m_mode[k] = M_RUN;
      m_left[k] = 0;
      m_prev[k] = 1'b0;
      m_out[k]  = 4'b0001;
    end else begin
      if (crash && (m_mode[k] inside {M_RUN, M_JUMP, M_DUCK})) begin
        m_mode[k] = M_CRASHED;
        m_left[k] = delay;
      end else begin
        case (m_mode[k])
          M_RUN: begin
            if (jr) begin m_mode[k] = M_JUMP; m_left[k] = J_HOLD; end
            else if (dr) m_mode[k] = M_DUCK;
          end
          M_JUMP: begin
            if (frame_tick) begin
              m_left[k]--;
              if (m_left[k] == 0) m_mode[k] = M_RUN;
            end
          end
          M_DUCK: begin
            if (jr) begin m_mode[k] = M_JUMP; m_left[k] = J_HOLD; end
            else if (!dr) m_mode[k] = M_RUN;
          end
          M_CRASHED: begin
            if (m_left[k] == 0) m_mode[k] = M_START;
            else if (frame_tick) m_left[k]--;
          end
          M_START: begin
            if (frame_tick && !crash) m_mode[k] = M_RUN;
          end
          default: ;
        endcase
      end
      m_out[k] = {m_mode[k] == M_START, m_mode[k] == M_JUMP, m_mode[k] == M_DUCK, 1'b1};
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    tick_seen = frame_tick;
    if (rst) begin
      model_reset(0);
      model_reset(1);
    end else begin
      model_step(0, 60);
      model_step(1, 0);
    end
    #1;
    check("model_d60", 32'({s0, u0, d0, a0}), 32'(m_out[0]));
    check("model_d0",  32'({s1, u1, d1, a1}), 32'(m_out[1]));
    cyc++;
    frame_tick = tick_rand ? ($urandom_range(0, 2) == 0) : ((cyc % 3) == 0);
  endtask

  initial begin
    set_pos(0, 500);
    set_pos(1, 500);
    model_reset(0);
    model_reset(1);
    repeat (3) cycle();
    check("reset_outputs", 32'({s0, u0, d0, a0}), 32'h1);
    rst = 1'b0;
    repeat (4) cycle();

    // Ground obstacle crossing the jump threshold, then hold length.
    set_pos(1, 31);
    cycle();
    check("jump_pre_threshold", 32'(u0), 32'd0);
    set_pos(1, 30);
    cycle();
    check("jump_rise", 32'(u0), 32'd1);
    ticks = 0;
    for (int n = 0; n < 100; n++) begin
      cycle();
      if (tick_seen) ticks++;
      if (!u0) break;
    end
    check("jump_hold_ticks", 32'(ticks), 32'd4);
    set_pos(1, 5);
    repeat (20) cycle();

    // Bird duck window, boundary at the player, and jump overriding duck.
    obstacle_is_bird[0] = 1'b1;
    set_pos(0, 35);
    cycle();
    check("duck_rise", 32'({u0, d0}), 32'h1);
    set_pos(0, 20);
    cycle();
    set_pos(1, 25);
    cycle();
    check("up_replaces_down", 32'({u0, d0}), 32'h2);
    set_pos(1, 600);
    repeat (20) cycle();
    check("duck_resume", 32'({u0, d0}), 32'h1);
    set_pos(0, 7);
    cycle();
    check("duck_at_7", 32'(d0), 32'd1);
    set_pos(0, 6);
    cycle();
    check("duck_past_player", 32'(d0), 32'd0);
    obstacle_is_bird[0] = 1'b0;
    set_pos(0, 600);
    repeat (4) cycle();

    // Crash during a jump, restart delay, start held while crash persists.
    set_pos(1, 30);
    cycle();
    check("crash_pre_jump", 32'(u0), 32'd1);
    crash = 1'b1;
    cycle();
    check("crash_up_drop", 32'(u0), 32'd0);
    check("zero_delay_not_yet", 32'(s1), 32'd0);
    crash = 1'b0;
    set_pos(1, 700);
    cycle();
    check("zero_delay_start", 32'(s1), 32'd1);
    ticks = tick_seen ? 1 : 0;
    for (int n = 0; n < 400; n++) begin
      cycle();
      if (s0) break;
      if (tick_seen) ticks++;
    end
    check("restart_delay_ticks", 32'(ticks), 32'd60);
    check("restart_start", 32'(s0), 32'd1);
    crash = 1'b1;
    repeat (9) begin
      cycle();
      check("start_hold_crash", 32'(s0), 32'd1);
    end
    crash = 1'b0;
    for (int n = 0; n < 10; n++) begin
      cycle();
      if (!s0) break;
    end
    check("start_release", 32'(s0), 32'd0);
    repeat (10) cycle();

    // Gamepad takeover with a live threat, then handover back to the AI.
    set_pos(1, 20);
    gamepad_is_present = 1'b1;
    gamepad_down = 1'b1;
    cycle();
    check("gamepad_mirror", 32'({s0, u0, d0, a0}), 32'h2);
    repeat (8) begin
      gamepad_start = 1'($urandom_range(0, 1));
      gamepad_up    = 1'($urandom_range(0, 1));
      gamepad_down  = 1'($urandom_range(0, 1));
      cycle();
      check("gamepad_ai_off", 32'(a0), 32'd0);
    end
    gamepad_is_present = 1'b0;
    gamepad_start = 1'b1;
    gamepad_up = 1'b1;
    gamepad_down = 1'b1;
    cycle();
    check("handover_quiet", 32'({s0, u0, d0, a0}), 32'h1);
    cycle();
    check("handover_up", 32'({u0, d0}), 32'h2);
    gamepad_start = 1'b0;
    gamepad_up = 1'b0;
    gamepad_down = 1'b0;
    set_pos(1, 700);
    repeat (20) cycle();

    // Asynchronous reset mid-jump.
    set_pos(1, 30);
    cycle();
    check("pre_reset_jump", 32'(u0), 32'd1);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_jump", 32'({s0, u0, d0, a0}), 32'h1);
    check("reset_mid_jump_d0", 32'({s1, u1, d1, a1}), 32'h1);
    model_reset(0);
    model_reset(1);
    set_pos(1, 700);
    cycle();
    rst = 1'b0;
    repeat (5) cycle();

    // Asynchronous reset with 30 restart ticks still pending.
    crash = 1'b1;
    cycle();
    crash = 1'b0;
    ticks = 0;
    for (int n = 0; n < 500 && ticks < 30; n++) begin
      cycle();
      if (tick_seen) ticks++;
    end
    check("crashed_ticks_before_reset", 32'(ticks), 32'd30);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_crashed", 32'({s0, u0, d0, a0}), 32'h1);
    model_reset(0);
    model_reset(1);
    cycle();
    rst = 1'b0;
    started = 1'b0;
    repeat (250) begin
      cycle();
      if (s0) started = 1'b1;
    end
    check("no_start_after_reset", 32'(started), 32'd0);

    // Randomized play.
    tick_rand = 1'b1;
    repeat (3000) begin
      for (int ch = 0; ch < int'(NUM_OBS); ch++) begin
        if ($urandom_range(0, 3) == 0)
          set_pos(ch, ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 1023))
                                                 : int'($urandom_range(0, 50)));
      end
      if ($urandom_range(0, 7) == 0) obstacle_is_bird = NUM_OBS'($urandom);
      if ($urandom_range(0, 79) == 0) crash = !crash;
      if ($urandom_range(0, 199) == 0) gamepad_is_present = !gamepad_is_present;
      gamepad_start = 1'($urandom_range(0, 1));
      gamepad_up    = 1'($urandom_range(0, 1));
      gamepad_down  = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ai_pilot.md
AI_PILOT -- requirements
Module: ai_pilot

Interface
REQ-001 Parameter CONV, default 0: dropped LSBs of obstacle positions; position width POS_W = 10-CONV.
REQ-002 Parameter NUM_OBS, default 2: number of obstacle channels, range 1..8.
REQ-003 Parameter PLAYER_OFFSET, default 6: obstacle x at or below this is already past the player.
REQ-004 Parameter JUMP_THRESHOLD, default 30: ground-obstacle x at or below this triggers a jump.
REQ-005 Parameter DUCK_THRESHOLD, default 40: bird x at or below this triggers a duck.
REQ-006 Parameter JUMP_HOLD, default 4: frame ticks button_up is held per jump, range 1..255.
REQ-007 Parameter RESTART_DELAY, default 60: frame ticks between crash and auto-restart, range 0..255.
REQ-008 clk  in  1  single system clock; all state on rising edge.
REQ-009 rst  in  1  asynchronous, active-high reset.
REQ-010 frame_tick  in  1  one-cycle pulse per game frame; all hold and delay counts advance on it.
REQ-011 gamepad_is_present, gamepad_start, gamepad_up, gamepad_down  in  1 each  human controller presence and buttons.
REQ-012 obstacle_pos  in  NUM_OBS*POS_W  packed x positions, channel i at bits [i*POS_W +: POS_W].
REQ-013 obstacle_is_bird  in  NUM_OBS  bit i set: channel i is an airborne obstacle (duck, not jump).
REQ-014 crash  in  1  level, high while game is in crashed state.
REQ-015 button_start, button_up, button_down  out  1 each  registered button commands to game core.
REQ-016 ai_active  out  1  high when the AI, not the gamepad, drives the buttons.

Function
REQ-017 Channel i SHALL be a jump threat when !bird_i and PLAYER_OFFSET < pos_i <= JUMP_THRESHOLD (unsigned); a duck threat when bird_i and PLAYER_OFFSET < pos_i <= DUCK_THRESHOLD.
REQ-018 jump_req = OR of jump threats; duck_req = OR of duck threats; if both, jump SHALL win.
REQ-019 FSM states SHALL be RUN, JUMP, DUCK, CRASHED, START.
REQ-020 RUN: crash -> CRASHED; else jump_req -> JUMP (hold counter = JUMP_HOLD); else duck_req -> DUCK; else stay; all buttons low.
REQ-021 JUMP: button_up=1; counter decrements on frame_tick; on frame_tick with counter==1 -> RUN; no retrigger while in JUMP.
REQ-022 DUCK: button_down=1; jump_req -> JUMP (button_down drops the same cycle button_up rises); !duck_req -> RUN.
REQ-023 CRASHED: buttons low; entry loads delay counter = RESTART_DELAY; decrements on frame_tick; counter==0 -> START; RESTART_DELAY=0 gives START one cycle after entry.
REQ-024 START: button_start=1; on frame_tick with crash low -> RUN; while crash high stay START.
REQ-025 crash SHALL take priority over every other transition from RUN, JUMP, DUCK.
REQ-026 Outputs SHALL be registered: one-cycle latency from any input change to button change.
REQ-027 gamepad_is_present high SHALL override: buttons mirror gamepad inputs with one-cycle latency, ai_active=0, FSM forced to RUN, counters cleared.
REQ-028 Presence falling SHALL resume AI in RUN next cycle with all buttons low before any new decision.
REQ-029 At most one of button_up, button_down SHALL be high in AI mode.

Reset
REQ-030 rst SHALL asynchronously force state RUN, all counters 0, button_start/up/down=0, ai_active=1.
REQ-031 Reset mid-JUMP or mid-CRASHED SHALL abandon the operation; no start pulse after release.

Structure
REQ-032 Package ai_pilot_pkg SHALL hold the state enumeration and default threshold/delay constants.
REQ-033 Sub-module obstacle_window (one position, bird flag -> jump/duck threat) SHALL be generated NUM_OBS times.
REQ-034 Counters SHALL be 8 bits.

Verification
REQ-035 NUM_OBS=2, ch1 ground pos 31->30 -> button_up rises next cycle, held exactly 4 frame_ticks, then RUN.
REQ-036 Bird at pos 35 -> button_down high until pos <= 6, then low; ground obstacle entering 25 meanwhile -> up replaces down.
REQ-037 crash pulse during JUMP -> up drops, 60 frame_ticks later button_start high until frame_tick with crash low.
REQ-038 RESTART_DELAY=0, crash -> button_start high two cycles after crash.
REQ-039 gamepad_is_present=1 with threat at pos 20 -> buttons follow gamepad only, ai_active=0; drop presence -> all low one cycle, then up.
REQ-040 rst asserted mid-CRASHED count (30 left) -> outputs 0 immediately; after release, crash low -> no start pulse.
